// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the SRAM controller.
//   state_e       - FSM encoding (IDLE, LO, HI, DONE)
//   HW_W          - SRAM halfword width
//   BASE_ADDR_DEF - default byte address mapped to SRAM word 0
//   word_off()    - byte address -> 32-bit word offset from the base, with the
//                   subtraction borrow in the MSB. The SRAM halfword address is
//                   {word, hi}, truncated to the SRAM address width.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    localparam int          HW_W          = 16;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    // Bit 30 is the borrow (address below base); bits 29:0 are the word index.
    // address[1:0] takes no part in the mapping.
    function automatic logic [30:0] word_off(input logic [31:0] addr, input logic [31:0] base);
        return {1'b0, addr[31:2]} - {1'b0, base[31:2]};
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request bus plus external SRAM pins.
//   Request side : memRead, memWrite, address, data -> memResult, ready
//   SRAM side    : sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n <- sram_dq_in
//   bus_err exists only when SRAM_BOUNDS_CHECK_EN is defined.
//   slave  = controller view, master = requester/board view.
interface sram_controller_if #(parameter int SRAM_AW = 18);
    logic               memRead;
    logic               memWrite;
    logic [31:0]        address;
    logic [31:0]        data;
    logic [31:0]        memResult;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;
`ifdef SRAM_BOUNDS_CHECK_EN
    logic               bus_err;

    modport slave  (input  memRead, memWrite, address, data, sram_dq_in,
                    output memResult, ready, sram_addr, sram_dq_out, sram_dq_oe,
                           sram_we_n, sram_oe_n, bus_err);
    modport master (output memRead, memWrite, address, data, sram_dq_in,
                    input  memResult, ready, sram_addr, sram_dq_out, sram_dq_oe,
                           sram_we_n, sram_oe_n, bus_err);
`else
    modport slave  (input  memRead, memWrite, address, data, sram_dq_in,
                    output memResult, ready, sram_addr, sram_dq_out, sram_dq_oe,
                           sram_we_n, sram_oe_n);
    modport master (output memRead, memWrite, address, data, sram_dq_in,
                    input  memResult, ready, sram_addr, sram_dq_out, sram_dq_oe,
                           sram_we_n, sram_oe_n);
`endif
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: phase timer counting 0..WAIT_CYCLES-1 and wrapping.
//   clk, rst  - clock, async active-low reset
//   clear     - force the count to 0 (dominates en)
//   en        - advance the count
//   cnt_q     - current count
//   cnt_d     - count after the next edge (lets the owner register outputs early)
//   last      - current count is WAIT_CYCLES-1
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = $clog2(WAIT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt_q,
    output logic [CW-1:0] cnt_d,
    output logic          last
);

    assign last = (cnt_q == CW'(WAIT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)    cnt_d = '0;
        else if (en)  cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sram_controller.sv
// sram_controller: MEM-stage data port driving a 16-bit asynchronous SRAM with
// two halfword phases (LO, HI) of WAIT_CYCLES each, then a one-cycle DONE.
//   clk, rst - clock, async active-low reset
//   bus      - sram_controller_if.slave (request bus + SRAM pins)
// ready is combinational; every other output is registered, so pin values
// are computed from the next state / next count.
// Optional: SRAM_BOUNDS_CHECK_EN adds an address range check and bus_err.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    sram_controller_if.slave bus
);

    localparam int CW = $clog2(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        mem_result_q, mem_result_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [HW_W-1:0]    dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               bus_err_q, bus_err_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last, cnt_en;
    logic               req, oob, phase;
    logic [30:0]        woff;

    assign req    = bus.memRead | bus.memWrite;
    assign woff   = word_off(bus.address, BASE_ADDR);
    assign cnt_en = (state_q == LO) || (state_q == HI);

`ifdef SRAM_BOUNDS_CHECK_EN
    // Borrow means address < BASE_ADDR; any word bit at or above SRAM_AW-1
    // means the word lies past the end of the device.
    assign oob = woff[30] | (|(woff[29:0] >> (SRAM_AW - 1)));
`else
    assign oob = 1'b0;
`endif

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES), .CW(CW)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clear (!cnt_en),
        .en    (cnt_en),
        .cnt_q (cnt_q),
        .cnt_d (cnt_d),
        .last  (last)
    );

    always_comb begin
        state_d      = state_q;
        op_wr_d      = op_wr_q;
        word_d       = word_q;
        data_d       = data_q;
        mem_result_d = mem_result_q;
        bus_err_d    = 1'b0;

        unique case (state_q)
            IDLE: if (req) begin
                op_wr_d = bus.memWrite;      // write wins when both are set
                word_d  = woff[SRAM_AW-2:0];
                data_d  = bus.data;
                if (oob) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                    if (!bus.memWrite) mem_result_d = '0;
                end else begin
                    state_d = LO;
                end
            end
            LO: if (last) begin
                state_d = HI;
                if (!op_wr_q) mem_result_d[15:0] = bus.sram_dq_in;
            end
            HI: if (last) begin
                state_d = DONE;
                if (!op_wr_q) mem_result_d[31:16] = bus.sram_dq_in;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values for the cycle being entered.
        phase       = (state_d == LO) || (state_d == HI);
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        if (phase) begin
            sram_addr_d = {word_d, state_d == HI};
            if (op_wr_d) dq_out_d = (state_d == HI) ? data_d[31:16] : data_d[15:0];
        end
        dq_oe_d = phase && op_wr_d;
        oe_n_d  = !(phase && !op_wr_d);
        // we_n released on the last count so address/data are held past the strobe.
        we_n_d  = !(phase && op_wr_d && (cnt_d != CW'(WAIT_CYCLES - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_wr_q      <= 1'b0;
            word_q       <= '0;
            data_q       <= '0;
            mem_result_q <= '0;
            sram_addr_q  <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_wr_q      <= op_wr_d;
            word_q       <= word_d;
            data_q       <= data_d;
            mem_result_q <= mem_result_d;
            sram_addr_q  <= sram_addr_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus.ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign bus.memResult   = mem_result_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_oe_n   = oe_n_q;
`ifdef SRAM_BOUNDS_CHECK_EN
    assign bus.bus_err     = bus_err_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench for sram_controller.
// Main DUT uses WAIT_CYCLES=2 against a small SRAM model; a second DUT with
// WAIT_CYCLES=4 and a constant read pattern checks the latency scaling.
// Builds with or without SRAM_BOUNDS_CHECK_EN.
module tb_sram_controller;
    import sram_ctrl_pkg::*;

    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if #(.SRAM_AW(AW)) bus();
    sram_controller_if #(.SRAM_AW(AW)) bus4();

    sram_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    sram_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));

    // SRAM model (low 1K halfwords are enough for the addresses used here)
    logic [15:0] mem [0:1023];
    assign bus.sram_dq_in  = !bus.sram_oe_n ? mem[bus.sram_addr[9:0]] : 16'h0;
    assign bus4.sram_dq_in = !bus4.sram_oe_n ? 16'hA5C3 : 16'h0;
    always @(posedge clk)
        if (!bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_addr[9:0]] <= bus.sram_dq_out;

    int cyc = 0, we_falls = 0, oe_falls = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge bus.sram_we_n) we_falls <= we_falls + 1;
    always @(negedge bus.sram_oe_n) oe_falls <= oe_falls + 1;

    int checks = 0, failures = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        bit          chk_res;
        bit          err;
        int          start;
        int          lat;
        string       tag;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   done_cnt = 0, last_done = 0;

    // Completion = request still held and ready high (DONE cycle).
    always @(negedge clk) begin
        if (rst && (bus.memRead || bus.memWrite) && bus.ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_lat"}, cyc - e.start, e.lat);
                if (e.chk_res) chk({e.tag, "_res"}, bus.memResult, e.res);
`ifdef SRAM_BOUNDS_CHECK_EN
                chk({e.tag, "_err"}, {31'd0, bus.bus_err}, {31'd0, e.err});
`endif
            end
            last_done <= cyc;
            done_cnt  <= done_cnt + 1;
        end
    end

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_res, input bit chk_res, input bit err, input string tag);
        int n;
        bus.memRead  = rd;
        bus.memWrite = wr;
        bus.address  = a;
        bus.data     = d;
        sb.push_back('{res: exp_res, chk_res: chk_res, err: err, start: cyc,
                       lat: err ? 1 : 5, tag: tag});
        n = done_cnt;
        for (int i = 0; i < 40 && done_cnt == n; i++) @(posedge clk);
        if (done_cnt == n) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        #1;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int c0, w0, o0, lat, lowcnt;
        bit seen;
        bus.memRead = 0;  bus.memWrite = 0;  bus.address = 0;  bus.data = 0;
        bus4.memRead = 0; bus4.memWrite = 0; bus4.address = 0; bus4.data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we_n",  {31'd0, bus.sram_we_n},  32'd1);
        chk("rst_oe_n",  {31'd0, bus.sram_oe_n},  32'd1);
        chk("rst_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
        chk("rst_addr",  {14'd0, bus.sram_addr},  32'd0);
        chk("rst_dqout", {16'd0, bus.sram_dq_out}, 32'd0);
        chk("rst_res",   bus.memResult, 32'd0);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Write then read
        w0 = we_falls;
        do_req(0, 1, 32'd1024, 32'hDEADBEEF, 32'd0, 0, 0, "wr0");
        chk("wr0_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        chk("wr0_mem1", {16'd0, mem[1]}, 32'h0000DEAD);
        chk("wr0_wepulses", we_falls - w0, 32'd2);
        do_req(1, 0, 32'd1024, 32'd0, 32'hDEADBEEF, 1, 0, "rd0");

        // Address map
        do_req(0, 1, 32'd1024 + 4 * 7, 32'h12345678, 32'd0, 0, 0, "wr7");
        chk("wr7_mem14", {16'd0, mem[14]}, 32'h00005678);
        chk("wr7_mem15", {16'd0, mem[15]}, 32'h00001234);
        chk("wr7_mem0",  {16'd0, mem[0]},  32'h0000BEEF);
        chk("wr7_mem1",  {16'd0, mem[1]},  32'h0000DEAD);
        do_req(1, 0, 32'd1024 + 4 * 7 + 3, 32'd0, 32'h12345678, 1, 0, "rd7");

        // Back-to-back: read, then write in the very next IDLE cycle
        c0 = cyc;
        do_req(1, 0, 32'd1024, 32'd0, 32'hDEADBEEF, 1, 0, "b2b_rd");
        do_req(0, 1, 32'd1024 + 12, 32'hCAFEF00D, 32'd0, 0, 0, "b2b_wr");
        chk("b2b_total", last_done - c0, 32'd11);
        chk("b2b_mem6", {16'd0, mem[6]}, 32'h0000F00D);
        chk("b2b_mem7", {16'd0, mem[7]}, 32'h0000CAFE);

        // Read and write both set: write wins, memResult untouched
        w0 = we_falls;
        do_req(1, 1, 32'd1024 + 20, 32'h0BADF00D, 32'hDEADBEEF, 1, 0, "both");
        chk("both_wepulses", we_falls - w0, 32'd2);
        chk("both_mem10", {16'd0, mem[10]}, 32'h0000F00D);
        chk("both_mem11", {16'd0, mem[11]}, 32'h00000BAD);

`ifdef SRAM_BOUNDS_CHECK_EN
        w0 = we_falls; o0 = oe_falls;
        do_req(1, 0, 32'd1024 + 4 * (2 ** 17), 32'd0, 32'd0, 1, 1, "oob_hi");
        do_req(1, 0, 32'd1024, 32'd0, 32'hDEADBEEF, 1, 0, "rd_again");
        o0 = oe_falls;
        do_req(1, 0, 32'd1000, 32'd0, 32'd0, 1, 1, "oob_lo");
        chk("oob_we_quiet", we_falls - w0, 32'd0);
        chk("oob_oe_quiet", oe_falls - o0, 32'd0);
`endif

        // Reset in the middle of a write strobe
        bus.memWrite = 1'b1; bus.address = 32'd1024 + 4 * 40; bus.data = 32'h55AA33CC;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = !bus.sram_we_n;
        end
        chk("mid_we_low", {31'd0, bus.sram_we_n}, 32'd0);
        rst = 1'b0;
        #1;
        bus.memWrite = 1'b0;
        #1;
        chk("mid_rst_we_n",  {31'd0, bus.sram_we_n},  32'd1);
        chk("mid_rst_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
        chk("mid_rst_oe_n",  {31'd0, bus.sram_oe_n},  32'd1);
        chk("mid_rst_res",   bus.memResult, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1, 0, 32'd1024 + 4 * 7, 32'd0, 32'h12345678, 1, 0, "post_rst_rd");

        // WAIT_CYCLES=4: read latency 9, write strobe low 3 cycles per phase
        bus4.memRead = 1'b1; bus4.address = 32'd1024 + 8;
        c0 = cyc; lat = -1;
        for (int i = 0; i < 30 && lat < 0; i++) begin
            @(negedge clk);
            if (bus4.ready) lat = cyc - c0;
        end
        chk("w4_rd_lat", lat, 32'd9);
        chk("w4_rd_res", bus4.memResult, 32'hA5C3A5C3);
        @(posedge clk); #1;
        bus4.memRead = 1'b0;
        bus4.memWrite = 1'b1; bus4.data = 32'h11112222;
        c0 = cyc; lat = -1; lowcnt = 0;
        for (int i = 0; i < 30 && lat < 0; i++) begin
            @(negedge clk);
            if (!bus4.sram_we_n) lowcnt++;
            if (bus4.ready) lat = cyc - c0;
        end
        chk("w4_wr_lat", lat, 32'd9);
        chk("w4_we_low_cycles", lowcnt, 32'd6);
        @(posedge clk); #1;
        bus4.memWrite = 1'b0;
        repeat (2) @(posedge clk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
